vga_scene_sequencer: RTL
========================

// Module: vga_scene_sequencer
// PURPOSE
//  Per-frame animation controller for the VGA pattern datapath. It detects the vsync rising
//  edge in the pixel clock domain and advances a frame counter that feeds the layer scroll math.
//  It sequences scenes through a fade-in / show / fade-out FSM and drives scene index and
//  brightness to the colour mux. Replaces clocking logic on posedge vsync.
// PARAMETERS
//  NUM_SCENES    4    scenes in rotation, >=1; scene wraps NUM_SCENES-1 -> 0
//  SCENE_FRAMES  256  frames spent in SHOW, >=1
//  FADE_FRAMES   8    frames per brightness step in FADE_IN/FADE_OUT, >=1
//  CNT_W         10   frame_count width
// PORTS
//  clk          in   1      pixel clock (25.175 MHz)
//  reset        in   1      synchronous, active-high
//  vsync        in   1      registered vsync from hvsync_generator
//  pause        in   1      level; freezes frame_count and FSM
//  speed        in   2      frame_count increment = speed+1 per frame
//  frame_count  out  CNT_W  animation counter, wraps mod 2^CNT_W
//  scene        out  2      current scene index
//  brightness   out  2      0..3 colour scale for output mux
//  frame_strobe out  1      1-cycle pulse per detected vsync rising edge
//  skip         in   1      (only with VGA_SEQ_MANUAL_SKIP_EN) pulse: request next scene
// BEHAVIOUR
//  - Reset: frame_count=0, scene=0, brightness=0, frame_strobe=0, state=FADE_IN, dwell=0,
//    vsync_q=1 (no false edge if vsync is high at reset release). Reset mid-frame aborts all.
//  - Edge: tick = vsync & ~vsync_q. frame_strobe and all state updates occur on the clock after
//    tick is seen, so outputs change 1 cycle after vsync rises (inside vblank, glitch-free).
//  - frame_strobe pulses on every tick, including while paused.
//  - On tick with pause=0: frame_count += speed+1 (mod 2^CNT_W). FSM steps once.
//  - On tick with pause=1: frame_count, dwell, state, scene, brightness hold.
//  - FSM (dwell = frames in current step):
//    FADE_IN : dwell==FADE_FRAMES-1 -> dwell=0, brightness+1; at brightness 3 -> SHOW.
//              Otherwise dwell+1.
//    SHOW    : brightness=3; dwell==SCENE_FRAMES-1 -> FADE_OUT, dwell=0; otherwise dwell+1.
//    FADE_OUT: dwell==FADE_FRAMES-1 -> dwell=0, brightness-1; at brightness 0 ->
//              scene=(scene+1)%NUM_SCENES, FADE_IN. Otherwise dwell+1.
//  - NUM_SCENES=1: scene stays 0, fade cycle still runs.
//  - No tick: every register holds (except vsync_q).
// CONFIGURATION
//  VGA_SEQ_MANUAL_SKIP_EN defined:
//  - skip port exists. A skip pulse on any cycle sets skip_pend. On the next unpaused tick:
//    - FADE_IN or SHOW: go to FADE_OUT with dwell=0; brightness is kept.
//    - FADE_OUT: no effect.
//    - skip_pend clears on that tick.
//  - skip on the same cycle as tick is applied at that tick. Reset clears skip_pend.
//  VGA_SEQ_MANUAL_SKIP_EN undefined:
//  - No skip port and no skip_pend. Sequencing is purely time-driven.
// STRUCTURE
//  - Shared package vga_seq_pkg: state encoding (FADE_IN=2'd0, SHOW=2'd1, FADE_OUT=2'd2),
//    BRIGHT_MAX=2'd3, and the 640x480 timing constants shared with hvsync_generator.
//  - Sub-module vga_frame_tick: vsync_q register plus rising-edge detect; outputs tick.
//  - Top level: frame counter, dwell counter (width clog2(max(SCENE_FRAMES,FADE_FRAMES))), FSM.
// TESTING
//  1. Reset, vsync low 3 cycles then high, speed=0 -> frame_strobe=1 exactly 1 cycle after
//     vsync rises; frame_count=1. Next 4 frames -> frame_count=5.
//  2. speed=3, frame_count=1020, one tick -> frame_count=0 (wrap). speed=1 -> 2 per frame.
//  3. FADE_FRAMES=2, SCENE_FRAMES=4: brightness 0,0,1,1,2,2,3, then SHOW 4 frames, then
//     3->0 over 6 frames, then scene=1. Scene goes 3->0 after the 4th fade-out (NUM_SCENES=4).
//  4. pause=1 across 10 vsync edges -> 10 frame_strobe pulses; frame_count, scene and
//     brightness unchanged; resumes from held values after pause=0.
//  5. reset asserted mid-SHOW with vsync held high -> all outputs 0; no strobe until vsync
//     falls and rises again.
//  6. (VGA_SEQ_MANUAL_SKIP_EN) skip pulse mid-SHOW, brightness=3 -> FADE_OUT at next tick.
//     skip during FADE_OUT -> ignored. skip with pause=1 -> held pending until the first
//     unpaused tick.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// Shared sequencer definitions: FSM encoding, brightness ceiling and 640x480 timing constants
// (the timing constants are also used by hvsync_generator).
package vga_seq_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    SHOW     = 2'd1,
    FADE_OUT = 2'd2
  } seq_state_e;

  localparam logic [1:0] BRIGHT_MAX = 2'd3;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // Dwell counter width: large enough for the longer of the SHOW and fade steps, at least 1 bit.
  function automatic int dwell_width(input int scene_frames, input int fade_frames);
    int m;
    int w;
    m = (scene_frames > fade_frames) ? scene_frames : fade_frames;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Vsync rising-edge detector in the pixel clock domain. The history register resets high so a
// vsync that is already high when reset releases does not produce a false tick.
module vga_frame_tick (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign tick = vsync & ~vsync_q;

endmodule

// File: rtl/vga_scene_sequencer.sv
// Per-frame animation controller: frame counter plus fade-in / show / fade-out scene FSM.
// Optional manual scene skip is compiled in with `define VGA_SEQ_MANUAL_SKIP_EN.
module vga_scene_sequencer
  import vga_seq_pkg::*;
#(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 256,
  parameter int FADE_FRAMES  = 8,
  parameter int CNT_W        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             pause,
  input  logic [1:0]       speed,
`ifdef VGA_SEQ_MANUAL_SKIP_EN
  input  logic             skip,
`endif
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       scene,
  output logic [1:0]       brightness,
  output logic             frame_strobe
);

  localparam int DW = dwell_width(SCENE_FRAMES, FADE_FRAMES);
  localparam logic [DW-1:0] FADE_LAST  = DW'(FADE_FRAMES - 1);
  localparam logic [DW-1:0] SHOW_LAST  = DW'(SCENE_FRAMES - 1);
  localparam logic [1:0]    SCENE_LAST = 2'(NUM_SCENES - 1);

  logic             tick;
  logic             step;
  logic             skip_now;
  seq_state_e       state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       bright_q, bright_d;
  logic [1:0]       scene_q, scene_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             strobe_q, strobe_d;

  vga_frame_tick u_frame_tick (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .tick  (tick)
  );

  assign step     = tick & ~pause;
  assign strobe_d = tick;

`ifdef VGA_SEQ_MANUAL_SKIP_EN
  logic skip_pend_q, skip_pend_d;

  // A request made on the tick cycle itself is honoured at that tick.
  assign skip_now    = skip_pend_q | skip;
  assign skip_pend_d = step ? 1'b0 : skip_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_pend_q <= 1'b0;
    end else begin
      skip_pend_q <= skip_pend_d;
    end
  end
`else
  assign skip_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FADE_IN;
      dwell_q       <= '0;
      bright_q      <= '0;
      scene_q       <= '0;
      frame_count_q <= '0;
      strobe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      bright_q      <= bright_d;
      scene_q       <= scene_d;
      frame_count_q <= frame_count_d;
      strobe_q      <= strobe_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    bright_d      = bright_q;
    scene_d       = scene_q;
    frame_count_d = frame_count_q;
    if (step) begin
      frame_count_d = frame_count_q + CNT_W'(speed) + CNT_W'(1);
      if (skip_now && (state_q != FADE_OUT)) begin
        state_d = FADE_OUT;
        dwell_d = '0;
      end else begin
        case (state_q)
          FADE_IN: begin
            if (dwell_q == FADE_LAST) begin
              dwell_d  = '0;
              bright_d = (bright_q == BRIGHT_MAX) ? BRIGHT_MAX : bright_q + 2'd1;
              if (bright_d == BRIGHT_MAX) state_d = SHOW;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
          SHOW: begin
            bright_d = BRIGHT_MAX;
            if (dwell_q == SHOW_LAST) begin
              state_d = FADE_OUT;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
          FADE_OUT: begin
            // Saturates at 0 so a skip taken from a dark FADE_IN still waits one fade step.
            if (dwell_q == FADE_LAST) begin
              dwell_d  = '0;
              bright_d = (bright_q == 2'd0) ? 2'd0 : bright_q - 2'd1;
              if (bright_d == 2'd0) begin
                scene_d = (scene_q >= SCENE_LAST) ? 2'd0 : scene_q + 2'd1;
                state_d = FADE_IN;
              end
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
          default: begin
            state_d  = FADE_IN;
            dwell_d  = '0;
            bright_d = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    frame_count  = frame_count_q;
    scene        = scene_q;
    brightness   = bright_q;
    frame_strobe = strobe_q;
  end

endmodule
